mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles spent in WAIT before an access is aborted; legal range 1..255.
REQ-002 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 Port rst, input, 1: reset, asynchronous and active-low (asserted when 0).
REQ-004 Port mem_read, input, 1: read request from the multicycle controller.
REQ-005 Port mem_write, input, 1: write request from the multicycle controller.
REQ-006 Port I_or_D, input, 1: address select (0 = pc_addr, 1 = alu_addr).
REQ-007 Port IR_write, input, 1: a read returns an instruction (load ir_out) rather than data (load mdr_out).
REQ-008 Port pc_addr, input, 32: instruction fetch address.
REQ-009 Port alu_addr, input, 32: data address from ALUOut.
REQ-010 Port wdata, input, 32: store data (register B).
REQ-011 Port ram_rdata, input, 32: read data from RAM, valid in the cycle ram_ack=1.
REQ-012 Port ram_ack, input, 1: RAM completion strobe.
REQ-013 Port ram_req, output, 1: RAM request, held until ack or abort.
REQ-014 Port ram_we, output, 1: RAM write enable, qualified by ram_req.
REQ-015 Port ram_addr, output, 32: registered RAM address.
REQ-016 Port ram_wdata, output, 32: registered RAM write data.
REQ-017 Port ir_out, output, 32: instruction register.
REQ-018 Port mdr_out, output, 32: memory data register.
REQ-019 Port busy, output, 1: stall to the controller; 1 in REQ and WAIT.
REQ-020 Port done, output, 1: one-cycle completion pulse.
REQ-021 Port err, output, 1: one-cycle error pulse.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, DONE, ERR, HOLD. All outputs are registered or decoded from state only.
REQ-023 IDLE, exactly one of mem_read/mem_write = 1, selected address [1:0] == 0: latch address, wdata, direction and IR_write, then go to REQ.
REQ-024 IDLE, mem_read=1 and mem_write=1 together: no RAM access, go to ERR.
REQ-025 IDLE, selected address [1:0] != 0: no RAM access, go to ERR.
REQ-026 REQ: ram_req=1 and ram_we=direction. If ram_ack=1 in this cycle, go to DONE; otherwise clear the 8-bit wait counter and go to WAIT.
REQ-027 WAIT: ram_req is held and the counter increments each cycle.
REQ-028 WAIT, ram_ack=1: go to DONE. If ram_ack=1 and counter==TIMEOUT occur in the same cycle, ack wins.
REQ-029 WAIT, counter==TIMEOUT with no ack: drop ram_req, go to ERR, leave ir_out/mdr_out unchanged.
REQ-030 Read data capture on the edge that samples ram_ack=1:
- latched IR_write=1: ram_rdata goes into ir_out.
- latched IR_write=0: ram_rdata goes into mdr_out.
- writes change neither register.
REQ-031 DONE: done=1 for one cycle, ram_req=0.
REQ-032 DONE exit: if mem_read or mem_write is still 1, go to HOLD; otherwise go to IDLE.
REQ-033 ERR: err=1 for one cycle, then go to HOLD when a request is still asserted, otherwise to IDLE.
REQ-034 HOLD: no access; stay until mem_read=0 and mem_write=0, then go to IDLE. A level-held request never causes a duplicate access.
REQ-035 Request inputs are ignored outside IDLE; latched address and data stay stable from REQ through DONE.
REQ-036 ram_ack outside REQ/WAIT is ignored.
REQ-037 Minimum read latency, request to done: 3 cycles (IDLE edge, REQ with ack, DONE).

Reset
REQ-038 rst=0 immediately, with no clock, forces state=IDLE and resets these outputs to 0: ram_req, ram_we, busy, done, err, ram_addr, ram_wdata, ir_out, mdr_out.
REQ-039 Reset mid-access drops ram_req asynchronously. After rst returns to 1, the first clock edge evaluates from IDLE.

Verification
REQ-040 Fetch: pc_addr=0x0000_0040, mem_read=1, IR_write=1, I_or_D=0, RAM ack in REQ with rdata=0x2008_0005 -> ram_addr=0x40, done pulses on cycle 3, ir_out=0x2008_0005, mdr_out unchanged.
REQ-041 Store with wait: alu_addr=0x100, wdata=0xDEAD_BEEF, mem_write=1, ack after 4 WAIT cycles -> ram_we=1 for the whole request, busy=1 for 5 cycles, done pulses once, ir_out/mdr_out unchanged.
REQ-042 Timeout: TIMEOUT=3, read with no ack -> ram_req falls after 3 WAIT cycles, err pulses once, mdr_out unchanged; request held -> HOLD until released.
REQ-043 Illegal requests:
- mem_read=mem_write=1 -> err pulse, ram_req never asserted.
- alu_addr=0x102 -> err pulse, ram_req never asserted.
REQ-044 Held request plus reset: mem_read held 10 cycles with immediate ack -> exactly one ram_req pulse. Then rst=0 during WAIT -> ram_req=0 with no clock edge, all outputs 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit between a multicycle CPU controller and a handshaked RAM.
// Runs one access per request, with a wait timeout, alignment/conflict errors and a hold state.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        I_or_D,
    input  logic        IR_write,
    input  logic [31:0] pc_addr,
    input  logic [31:0] alu_addr,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [31:0] ir_out,
    output logic [31:0] mdr_out,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR, S_HOLD} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic        dir;
    logic        irw;
    logic [31:0] sel_addr;
    logic        any_req;

    assign sel_addr = I_or_D ? alu_addr : pc_addr;
    assign any_req  = mem_read | mem_write;
    assign cnt_nxt  = cnt + 8'd1;

    // Strobes are pure state decodes, so an async reset clears them with no clock.
    assign ram_req = (state == S_REQ) || (state == S_WAIT);
    assign busy    = ram_req;
    assign ram_we  = ram_req && dir;
    assign done    = (state == S_DONE);
    assign err     = (state == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            dir       <= 1'b0;
            irw       <= 1'b0;
            ram_addr  <= 32'd0;
            ram_wdata <= 32'd0;
            ir_out    <= 32'd0;
            mdr_out   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_read && mem_write) begin
                        state <= S_ERR;
                    end else if (any_req) begin
                        if (sel_addr[1:0] != 2'b00) begin
                            state <= S_ERR;
                        end else begin
                            ram_addr  <= sel_addr;
                            ram_wdata <= wdata;
                            dir       <= mem_write;
                            irw       <= IR_write;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (ram_ack) begin
                        if (!dir) begin
                            if (irw) ir_out  <= ram_rdata;
                            else     mdr_out <= ram_rdata;
                        end
                        state <= S_DONE;
                    end else if (state == S_REQ) begin
                        cnt   <= 8'd0;
                        state <= S_WAIT;
                    end else if (cnt_nxt == TO) begin
                        // cnt_nxt counts WAIT cycles spent, including this one
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_DONE, S_ERR: state <= any_req ? S_HOLD : S_IDLE;
                S_HOLD:        if (!any_req) state <= S_IDLE;
                default:       state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: driver pushes expected outcomes, monitor checks responses.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, I_or_D = 1'b0, IR_write = 1'b0;
    logic [31:0] pc_addr = '0, alu_addr = '0, wdata = '0, ram_rdata = '0;
    logic        ram_ack = 1'b0;
    logic        ram_req, ram_we, busy, done, err;
    logic [31:0] ram_addr, ram_wdata, ir_out, mdr_out;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .I_or_D(I_or_D), .IR_write(IR_write), .pc_addr(pc_addr), .alu_addr(alu_addr),
        .wdata(wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack), .ram_req(ram_req),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ir_out(ir_out),
        .mdr_out(mdr_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] ir;
        logic [31:0] mdr;
        int          req_cyc;
    } exp_t;

    exp_t        q[$];
    int          compared = 0, mismatched = 0;
    int          resp_cnt = 0;
    int          req_cyc = 0, we_cyc = 0, busy_cyc = 0;
    logic [31:0] exp_ir = '0, exp_mdr = '0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: accumulates strobe cycles and scores each done/err pulse against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (ram_req) req_cyc++;
            if (ram_we) we_cyc++;
            if (busy) busy_cyc++;
            if (done || err) begin
                resp_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_resp", {30'd0, done, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done", {31'd0, done}, {31'd0, !e.is_err});
                    check("err", {31'd0, err}, {31'd0, e.is_err});
                    check("req_cycles", req_cyc, e.req_cyc);
                    check("we_cycles", we_cyc, e.is_wr ? e.req_cyc : 0);
                    check("busy_cycles", busy_cyc, e.req_cyc);
                    check("ir_out", ir_out, e.ir);
                    check("mdr_out", mdr_out, e.mdr);
                    if (!e.is_err) begin
                        check("ram_addr", ram_addr, e.addr);
                        if (e.is_wr) check("ram_wdata", ram_wdata, e.wd);
                    end
                end
                req_cyc = 0; we_cyc = 0; busy_cyc = 0;
            end
        end
    end

    // dly: cycle index of the ack (0 = in REQ, k = k-th WAIT cycle); hold: extra cycles request stays up.
    task automatic do_txn(bit rd, bit wr, bit iord, logic [31:0] addr, bit irw,
                          logic [31:0] rdata, logic [31:0] wd, int dly, int hold);
        exp_t e;
        bit   illegal;
        int   start, n;
        @(negedge clk);
        mem_read = rd; mem_write = wr; I_or_D = iord; IR_write = irw; wdata = wd;
        pc_addr  = iord ? $urandom : addr;
        alu_addr = iord ? addr : $urandom;
        ram_rdata = rdata;
        ram_ack = 1'b0;
        illegal = (rd && wr) || (addr[1:0] != 2'b00);
        e.is_wr = wr && !illegal;
        e.addr = addr; e.wd = wd;
        if (illegal) begin
            e.is_err = 1'b1; e.req_cyc = 0;
        end else if (dly <= TO) begin
            e.is_err = 1'b0; e.req_cyc = dly + 1;
            if (rd) begin
                if (irw) exp_ir = rdata;
                else     exp_mdr = rdata;
            end
        end else begin
            e.is_err = 1'b1; e.req_cyc = TO + 1;
        end
        e.ir = exp_ir; e.mdr = exp_mdr;
        q.push_back(e);
        start = resp_cnt;
        @(posedge clk); #1;
        if (hold == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
        if (!illegal) begin
            for (int c = 0; c <= TO; c++) begin
                ram_ack = (c == dly);
                @(posedge clk); #1;
                ram_ack = 1'b0;
                if (c == dly) break;
            end
        end
        n = 0;
        while (resp_cnt == start && n < 50) begin
            ram_ack = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
            @(posedge clk); #1;
            n++;
        end
        if (resp_cnt == start) check("resp_timeout", 32'd0, 32'd1);
        for (int h = 0; h < hold; h++) begin
            ram_ack = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; ram_ack = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2;
        check("rst_ram_req", {31'd0, ram_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_ir", ir_out, 32'd0);
        check("rst_mdr", mdr_out, 32'd0);
        check("rst_addr", ram_addr, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);

        do_txn(1, 0, 0, 32'h40, 1, 32'h2008_0005, 32'h0, 0, 0);        // fetch
        do_txn(0, 1, 1, 32'h100, 0, 32'h0, 32'hDEAD_BEEF, 4, 0);       // store, ack at timeout boundary
        do_txn(1, 0, 1, 32'h200, 0, 32'h1234_5678, 32'h0, 99, 3);      // timeout with held request
        do_txn(1, 1, 1, 32'h300, 0, 32'h0, 32'h0, 0, 0);               // read+write conflict
        do_txn(1, 0, 1, 32'h102, 0, 32'h0, 32'h0, 0, 0);               // misaligned
        do_txn(1, 0, 1, 32'h400, 0, 32'hCAFE_F00D, 32'h0, 0, 10);      // held read, single access

        for (int i = 0; i < 60; i++) begin
            bit rd, wr;
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            rd = (sel < 5) || (sel == 9);
            wr = (sel >= 5);
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            do_txn(rd, wr, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(0, TO + 2), $urandom_range(0, 3));
        end

        // Reset in the middle of WAIT must drop everything without a clock edge.
        @(negedge clk);
        mem_read = 1'b1; I_or_D = 1'b1; alu_addr = 32'h500; ram_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_ram_req", {31'd0, ram_req}, 32'd0);
        check("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done_err", {30'd0, done, err}, 32'd0);
        check("mid_rst_addr", ram_addr, 32'd0);
        check("mid_rst_wdata", ram_wdata, 32'd0);
        check("mid_rst_ir", ir_out, 32'd0);
        check("mid_rst_mdr", mdr_out, 32'd0);
        mem_read = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        if (q.size() != 0) check("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
